// File: rtl/player_input_sampler.sv
// Button front end for the physics FSM: 2-flop synchroniser, per-bit debouncer, press-edge
// latches and a once-per-frame frozen command snapshot offered over a valid/ack handshake.
module player_input_sampler #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] btn_raw,
   input  logic       frame_req,
   input  logic       cmd_ack,
   output logic       cmd_valid,
   output logic       move_right,
   output logic       move_left,
   output logic       jump_hold,
   output logic       jump_press,
   output logic       serve_press,
   output logic [3:0] btn_level,
   output logic [7:0] overrun_cnt
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } state_e;

   logic [3:0]       sync1_q, sync2_q;
   logic [3:0]       stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];
   logic [1:0]       stable_prev_q, stable_prev_d;   // [0]=jump, [1]=serve
   logic [1:0]       rise_s;
   logic [1:0]       pend_q, pend_d;                 // [0]=jump, [1]=serve
   logic [1:0]       ack_clr_s;
   state_e           state_q, state_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic [4:0]       snap_q, snap_d;                 // {right, left, jump_hold, jump_press, serve_press}
   logic [7:0]       overrun_q, overrun_d;

   function automatic logic [4:0] make_snap(input logic [3:0] lvl, input logic [1:0] pend);
      return {lvl[0] & ~lvl[2], lvl[2] & ~lvl[0], lvl[1], pend[0], pend[1]};
   endfunction

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cnt_d[i]    = CNT_ZERO;
         stable_d[i] = stable_q[i];
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = CNT_ZERO;
         end else if (cnt_q[i] == CNT_LAST) begin
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = CNT_ZERO;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end
      end
   end

   // A fresh edge on the ack cycle must survive the clear of the bit it was captured from.
   always_comb begin
      stable_prev_d = {stable_q[3], stable_q[1]};
      rise_s        = {stable_q[3] & ~stable_prev_q[1], stable_q[1] & ~stable_prev_q[0]};
      if ((state_q == ST_PRESENT) && cmd_ack) begin
         ack_clr_s = {snap_q[0], snap_q[1]};
      end else begin
         ack_clr_s = 2'b00;
      end
      pend_d = (pend_q & ~ack_clr_s) | rise_s;
   end

   always_comb begin
      state_d     = state_q;
      cmd_valid_d = cmd_valid_q;
      snap_d      = snap_q;
      overrun_d   = overrun_q;
      case (state_q)
         ST_IDLE: begin
            if (frame_req) begin
               state_d     = ST_PRESENT;
               cmd_valid_d = 1'b1;
               snap_d      = make_snap(stable_q, pend_q);
            end else begin
               cmd_valid_d = 1'b0;
               snap_d      = 5'b00000;
            end
         end
         ST_PRESENT: begin
            if (cmd_ack && frame_req) begin
               cmd_valid_d = 1'b1;
               snap_d      = make_snap(stable_q, pend_d);
            end else if (cmd_ack) begin
               state_d     = ST_IDLE;
               cmd_valid_d = 1'b0;
               snap_d      = 5'b00000;
            end else if (frame_req) begin
               if (overrun_q != 8'hFF) begin
                  overrun_d = overrun_q + 8'd1;
               end else begin
                  overrun_d = overrun_q;
               end
            end else begin
               cmd_valid_d = 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            cmd_valid_d = 1'b0;
            snap_d      = 5'b00000;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q       <= 4'b0000;
         sync2_q       <= 4'b0000;
         stable_q      <= 4'b0000;
         stable_prev_q <= 2'b00;
         pend_q        <= 2'b00;
         state_q       <= ST_IDLE;
         cmd_valid_q   <= 1'b0;
         snap_q        <= 5'b00000;
         overrun_q     <= 8'd0;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= CNT_ZERO;
         end
      end else begin
         sync1_q       <= btn_raw;
         sync2_q       <= sync1_q;
         stable_q      <= stable_d;
         stable_prev_q <= stable_prev_d;
         pend_q        <= pend_d;
         state_q       <= state_d;
         cmd_valid_q   <= cmd_valid_d;
         snap_q        <= snap_d;
         overrun_q     <= overrun_d;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign cmd_valid   = cmd_valid_q;
   assign move_right  = snap_q[4];
   assign move_left   = snap_q[3];
   assign jump_hold   = snap_q[2];
   assign jump_press  = snap_q[1];
   assign serve_press = snap_q[0];
   assign btn_level   = stable_q;
   assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_player_input_sampler.sv
// Bench for player_input_sampler: directed vector table, hand-written corner sequences and
// random stimulus, all checked against a behavioural model of the button/frame rules.
module tb_player_input_sampler;

   localparam int DEB = 4;
   localparam int CW  = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] btn_raw;
   logic       frame_req;
   logic       cmd_ack;
   logic       cmd_valid, move_right, move_left, jump_hold, jump_press, serve_press;
   logic [3:0] btn_level;
   logic [7:0] overrun_cnt;

   int total = 0;
   int bad   = 0;
   int stepn = 0;

   player_input_sampler #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .btn_raw(btn_raw), .frame_req(frame_req), .cmd_ack(cmd_ack),
      .cmd_valid(cmd_valid), .move_right(move_right), .move_left(move_left),
      .jump_hold(jump_hold), .jump_press(jump_press), .serve_press(serve_press),
      .btn_level(btn_level), .overrun_cnt(overrun_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [3:0] raw_hist [$];   // raw samples of the last two edges
   logic [3:0] win [$];        // last DEB values seen by the debouncer
   logic [3:0] m_stable, m_prev;
   logic       m_pj, m_ps;
   logic       m_valid, m_mr, m_ml, m_jh, m_jp, m_sp;
   int         m_ovr;

   task automatic model_reset();
      raw_hist.delete();
      win.delete();
      m_stable = 4'b0000; m_prev = 4'b0000;
      m_pj = 1'b0; m_ps = 1'b0;
      m_valid = 1'b0; m_mr = 1'b0; m_ml = 1'b0; m_jh = 1'b0; m_jp = 1'b0; m_sp = 1'b0;
      m_ovr = 0;
   endtask

   task automatic take_snap(input logic pj, input logic ps);
      m_mr = m_stable[0] && !m_stable[2];
      m_ml = m_stable[2] && !m_stable[0];
      m_jh = m_stable[1];
      m_jp = pj;
      m_sp = ps;
   endtask

   task automatic model_edge();
      logic       r1, r3, pj, ps, all_diff;
      logic [3:0] samp, nxt;
      r1 = m_stable[1] && !m_prev[1];
      r3 = m_stable[3] && !m_prev[3];
      pj = (m_pj && !(m_valid && cmd_ack && m_jp)) || r1;
      ps = (m_ps && !(m_valid && cmd_ack && m_sp)) || r3;
      if (!m_valid) begin
         if (frame_req) begin
            m_valid = 1'b1;
            take_snap(m_pj, m_ps);
         end
      end else if (cmd_ack) begin
         if (frame_req) begin
            take_snap(pj, ps);
         end else begin
            m_valid = 1'b0;
            m_mr = 1'b0; m_ml = 1'b0; m_jh = 1'b0; m_jp = 1'b0; m_sp = 1'b0;
         end
      end else if (frame_req) begin
         if (m_ovr < 255) m_ovr = m_ovr + 1;
      end
      m_pj = pj;
      m_ps = ps;
      samp = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size() - 2] : 4'b0000;
      raw_hist.push_back(btn_raw);
      if (raw_hist.size() > 2) void'(raw_hist.pop_front());
      win.push_back(samp);
      if (win.size() > DEB) void'(win.pop_front());
      nxt = m_stable;
      for (int b = 0; b < 4; b++) begin
         if (win.size() == DEB) begin
            all_diff = 1'b1;
            foreach (win[k]) if (win[k][b] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) nxt[b] = ~m_stable[b];
         end
      end
      m_prev   = m_stable;
      m_stable = nxt;
   endtask

   function automatic logic [17:0] dut_vec();
      return {cmd_valid, move_right, move_left, jump_hold, jump_press, serve_press, btn_level, overrun_cnt};
   endfunction

   function automatic logic [17:0] model_vec();
      return {m_valid, m_mr, m_ml, m_jh, m_jp, m_sp, m_stable, 8'(m_ovr)};
   endfunction

   task automatic chk(input string name, input logic [17:0] got, input logic [17:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s (step %0d): got %h want %h", name, stepn, got, want);
      end
   endtask

   task automatic step(input logic [3:0] r, input logic fr, input logic ak);
      btn_raw = r; frame_req = fr; cmd_ack = ak;
      @(posedge clk);
      if (reset) model_reset(); else model_edge();
      #1;
      stepn++;
      chk("model", dut_vec(), model_vec());
   endtask

   task automatic hold(input logic [3:0] r, input int n);
      for (int i = 0; i < n; i++) step(r, 1'b0, 1'b0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0]  raw;
      logic        req;
      logic        ack;
      logic [17:0] exp;   // {valid, right, left, jhold, jpress, spress, level, overrun}
   } vec_t;

   vec_t tbl [22];

   function automatic vec_t mk(input logic [3:0] r, input logic q, input logic a,
                               input logic v, input logic [4:0] s, input logic [3:0] l);
      vec_t t;
      t.raw = r; t.req = q; t.ack = a;
      t.exp = {v, s, l, 8'd0};
      return t;
   endfunction

   initial begin
      logic [3:0] rr;
      int         hl;

      tbl[0] = mk(4'b0000, 1'b0, 1'b0, 1'b0, 5'b00000, 4'b0000);
      tbl[1] = mk(4'b0000, 1'b1, 1'b0, 1'b1, 5'b00000, 4'b0000);
      tbl[2] = mk(4'b0000, 1'b0, 1'b0, 1'b1, 5'b00000, 4'b0000);
      tbl[3] = mk(4'b0000, 1'b0, 1'b1, 1'b0, 5'b00000, 4'b0000);
      tbl[4] = mk(4'b0000, 1'b0, 1'b1, 1'b0, 5'b00000, 4'b0000);
      for (int i = 5; i < 10; i++) tbl[i] = mk(4'b0001, 1'b0, 1'b0, 1'b0, 5'b00000, 4'b0000);
      tbl[10] = mk(4'b0001, 1'b0, 1'b0, 1'b0, 5'b00000, 4'b0001);
      tbl[11] = mk(4'b0001, 1'b1, 1'b0, 1'b1, 5'b10000, 4'b0001);
      tbl[12] = mk(4'b0001, 1'b0, 1'b1, 1'b0, 5'b00000, 4'b0001);
      for (int i = 13; i < 16; i++) tbl[i] = mk(4'b1001, 1'b0, 1'b0, 1'b0, 5'b00000, 4'b0001);
      for (int i = 16; i < 22; i++) tbl[i] = mk(4'b0001, 1'b0, 1'b0, 1'b0, 5'b00000, 4'b0001);

      btn_raw = 4'b0000; frame_req = 1'b0; cmd_ack = 1'b0;
      reset = 1'b1;
      model_reset();
      hold(4'b0000, 3);
      chk("reset_state", dut_vec(), 18'd0);
      reset = 1'b0;

      foreach (tbl[k]) begin
         step(tbl[k].raw, tbl[k].req, tbl[k].ack);
         chk($sformatf("vec[%0d]", k), dut_vec(), tbl[k].exp);
      end

      // jump pressed and released between frames: edge is remembered, level is not
      hold(4'b0011, 8);
      hold(4'b0001, 8);
      step(4'b0001, 1'b1, 1'b0);
      chk("jp_between_frames", {cmd_valid, jump_press, jump_hold}, {15'd0, 3'b110});
      step(4'b0001, 1'b0, 1'b1);
      chk("jp_ack_valid", {17'd0, cmd_valid}, 18'd0);
      step(4'b0001, 1'b1, 1'b0);
      chk("jp_consumed", {cmd_valid, jump_press}, {16'd0, 2'b10});
      step(4'b0001, 1'b0, 1'b1);

      // both directions held
      hold(4'b0101, 8);
      step(4'b0101, 1'b1, 1'b0);
      chk("both_dirs", {cmd_valid, move_right, move_left}, {15'd0, 3'b100});
      step(4'b0101, 1'b0, 1'b1);

      // overruns while presenting leave the snapshot frozen
      hold(4'b0100, 8);
      step(4'b0100, 1'b1, 1'b0);
      chk("left_only", {cmd_valid, move_right, move_left}, {15'd0, 3'b101});
      for (int i = 0; i < 3; i++) begin
         step(4'b0001, 1'b1, 1'b0);
         step(4'b0001, 1'b0, 1'b0);
      end
      hold(4'b0001, 6);
      chk("ovr3_level", {14'd0, btn_level}, 18'd1);
      chk("ovr3_frozen", {cmd_valid, move_right, move_left, overrun_cnt},
          {7'd0, 3'b101, 8'd3});
      for (int i = 0; i < 300; i++) step(4'b0001, 1'b1, 1'b0);
      chk("ovr_saturate", {10'd0, overrun_cnt}, 18'd255);
      step(4'b0001, 1'b0, 1'b1);

      // ack+req on the cycle a jump edge appears
      step(4'b0001, 1'b1, 1'b0);
      hold(4'b0011, 6);
      chk("pre_ackreq_jp", {16'd0, cmd_valid, jump_press}, 18'd2);
      step(4'b0011, 1'b1, 1'b1);
      chk("ackreq_edge", {cmd_valid, jump_press, jump_hold, overrun_cnt},
          {7'd0, 3'b111, 8'd255});
      step(4'b0011, 1'b0, 1'b1);

      // reset while presenting aborts everything
      step(4'b0011, 1'b1, 1'b0);
      reset = 1'b1;
      step(4'b0011, 1'b0, 1'b0);
      chk("reset_mid_present", dut_vec(), 18'd0);
      reset = 1'b0;

      // random phase
      rr = 4'b0000; hl = 0;
      for (int n = 0; n < 3000; n++) begin
         if (hl == 0) begin
            rr = 4'($urandom_range(0, 15));
            hl = $urandom_range(1, 9);
         end
         hl--;
         step(rr, ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
